// File: rtl/uart_ack_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_ack_frame_tx
//
// Purpose:
//   This block sends a fixed 7-byte acknowledge frame over a UART line, using
//   8N1 format:
//       0x55, func, ch, sta, code, CRC-8, 0xAA
//   The CRC is CRC-8 with polynomial 0x07 and initial value 0x00. It is
//   computed MSB-first, with no reflection and no final XOR, over the four
//   bytes captured when the request was accepted.
//   All bytes go out back-to-back with no idle time between them. Each bit
//   lasts BAUD_DIV = CLK_FREQ/UART_BPS sys_clk cycles.
//
// Ports:
//   sys_clk    : the single clock; all logic works on its rising edge
//   sys_rst    : asynchronous active-high reset; aborts any frame in progress
//   ack_valid  : a response frame is requested
//   ack_ready  : high when a request can be accepted (same as !tx_busy)
//   ack_func   : echoed register function byte
//   ack_ch     : echoed channel byte
//   ack_sta    : echoed control/status byte
//   ack_code   : result code (0x00 OK, 0x01 CRC error)
//   uart_txd   : registered serial output, high when idle
//   tx_busy    : high from the accepting edge until the FSM returns to IDLE
//   frame_done : one-cycle pulse on the edge that returns the FSM to IDLE
// -----------------------------------------------------------------------------
module uart_ack_frame_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       ack_valid,
    output logic       ack_ready,
    input  logic [7:0] ack_func,
    input  logic [7:0] ack_ch,
    input  logic [7:0] ack_sta,
    input  logic [7:0] ack_code,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       frame_done
);

    localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       byte_idx;
    logic [7:0]       func_q;
    logic [7:0]       ch_q;
    logic [7:0]       sta_q;
    logic [7:0]       code_q;
    logic [7:0]       crc;
    logic [7:0]       cur_byte;
    logic             bit_end;
    logic             accept;
    logic             last_byte;
    logic             line_next;
    logic             done_next;

    // Processes one byte through CRC-8 (poly 0x07), MSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    // The CRC only depends on the captured bytes. Those bytes stay fixed for
    // the whole frame, so the CRC is already stable when byte 5 goes out.
    assign crc = crc8_step(crc8_step(crc8_step(crc8_step(8'h00, func_q),
                                               ch_q), sta_q), code_q);

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign accept    = (state == IDLE) && ack_valid;
    assign last_byte = (byte_idx == 3'd6);
    assign tx_busy   = (state != IDLE);
    assign ack_ready = ~tx_busy;

    // Selects the frame byte for the current byte index.
    always_comb begin
        cur_byte = 8'hAA;
        case (byte_idx)
            3'd0:    cur_byte = 8'h55;
            3'd1:    cur_byte = func_q;
            3'd2:    cur_byte = ch_q;
            3'd3:    cur_byte = sta_q;
            3'd4:    cur_byte = code_q;
            3'd5:    cur_byte = crc;
            default: cur_byte = 8'hAA;
        endcase
    end

    // Next-state logic and the line level for the next cycle.
    // uart_txd registers line_next, so the line follows the FSM one cycle
    // late. As a result the start bit begins on the edge after the accepting
    // edge, and the final stop bit ends one cycle after the FSM is back in
    // IDLE.
    always_comb begin
        state_next = state;
        line_next  = 1'b1;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (ack_valid) begin
                    state_next = START;
                end
            end
            START: begin
                line_next = 1'b0;
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                line_next = cur_byte[bit_idx];
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_byte) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = START;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset returns the FSM to IDLE straight away, and the
    // aborted frame is never resumed.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: baud counter, bit and byte indices, captured request bytes,
    // and the registered line and done outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 3'd0;
            func_q     <= 8'h00;
            ch_q       <= 8'h00;
            sta_q      <= 8'h00;
            code_q     <= 8'h00;
            uart_txd   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            uart_txd   <= line_next;
            frame_done <= done_next;

            if (accept) begin
                func_q <= ack_func;
                ch_q   <= ack_ch;
                sta_q  <= ack_sta;
                code_q <= ack_code;
            end

            if ((state == IDLE) || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            if (state == IDLE) begin
                bit_idx <= 3'd0;
            end else if ((state == DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (accept) begin
                byte_idx <= 3'd0;
            end else if ((state == STOP) && bit_end) begin
                byte_idx <= last_byte ? 3'd0 : (byte_idx + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_uart_ack_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_ack_frame_tx
//
// Purpose:
//   Self-checking bench for uart_ack_frame_tx. It uses two instances:
//     - one with default parameters (434-cycle bits), which sends one frame;
//     - one fast instance with an 11-cycle bit period, which runs the
//       remaining scenarios.
//   The reference model builds the expected 70-bit line stream from the frame
//   rules. Its CRC is a polynomial long division, not a byte-wise shift loop.
//   Every cycle of each frame is compared with that stream. Bytes are also
//   decoded by sampling at the bit centre.
// -----------------------------------------------------------------------------
module tb_uart_ack_frame_tx;

    localparam int D_DEF     = 50_000_000 / 115200;
    localparam int FAST_CLK  = 1_267_200;
    localparam int FAST_BPS  = 115200;
    localparam int D_FAST    = FAST_CLK / FAST_BPS;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       ack_valid;
    logic [7:0] ack_func;
    logic [7:0] ack_ch;
    logic [7:0] ack_sta;
    logic [7:0] ack_code;
    logic       use_def;

    logic ready_d, txd_d, busy_d, done_d;
    logic ready_f, txd_f, busy_f, done_f;
    logic ready_s, txd_s, busy_s, done_s;
    logic valid_d, valid_f;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    assign valid_d = ack_valid & use_def;
    assign valid_f = ack_valid & ~use_def;
    assign ready_s = use_def ? ready_d : ready_f;
    assign txd_s   = use_def ? txd_d   : txd_f;
    assign busy_s  = use_def ? busy_d  : busy_f;
    assign done_s  = use_def ? done_d  : done_f;

    uart_ack_frame_tx dut_def (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ack_valid  (valid_d),
        .ack_ready  (ready_d),
        .ack_func   (ack_func),
        .ack_ch     (ack_ch),
        .ack_sta    (ack_sta),
        .ack_code   (ack_code),
        .uart_txd   (txd_d),
        .tx_busy    (busy_d),
        .frame_done (done_d)
    );

    uart_ack_frame_tx #(
        .CLK_FREQ (FAST_CLK),
        .UART_BPS (FAST_BPS)
    ) dut_fast (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ack_valid  (valid_f),
        .ack_ready  (ready_f),
        .ack_func   (ack_func),
        .ack_ch     (ack_ch),
        .ack_sta    (ack_sta),
        .ack_code   (ack_code),
        .uart_txd   (txd_f),
        .tx_busy    (busy_f),
        .frame_done (done_f)
    );

    // CRC-8/0x07 as the remainder of (message * x^8) mod x^8+x^2+x+1.
    function automatic logic [7:0] model_crc(input logic [31:0] msg);
        logic [39:0] r;
        r = {msg, 8'h00};
        for (int i = 39; i >= 8; i--) begin
            if (r[i]) begin
                r = r ^ (40'h107 << (i - 8));
            end
        end
        return r[7:0];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives a request at the current falling edge. It is accepted on the
    // next rising edge.
    task automatic apply_stimulus(input logic [7:0] f, input logic [7:0] c,
                                  input logic [7:0] s, input logic [7:0] cd);
        ack_func  = f;
        ack_ch    = c;
        ack_sta   = s;
        ack_code  = cd;
        ack_valid = 1'b1;
    endtask

    // Checks that the line stays idle for n cycles.
    task automatic check_idle(input string tag, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (txd_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0) begin
                bad++;
            end
        end
        check_output(tag, bad, 0);
    endtask

    // Follows one frame from the accepting edge, starting at the falling edge
    // just before it.
    //   k counts falling edges after the accepting edge.
    //   Line bit j = k-1 is expected to equal stream[j/D].
    //   inject_k > 0 : present a different request in the middle of the frame.
    //   reset_k  > 0 : assert reset at that point instead of finishing.
    //   hold         : leave ack_valid high through to frame_done.
    task automatic check_frame(input logic [7:0] f, input logic [7:0] c,
                               input logic [7:0] s, input logic [7:0] cd,
                               input bit hold, input int inject_k,
                               input int reset_k);
        logic [7:0] exp_b [7];
        logic       stream [70];
        logic [9:0] dec [7];
        int d, line_err, busy_err, done_err, done_cnt, last_k, j, jb, bad;
        d = use_def ? D_DEF : D_FAST;
        exp_b = '{8'h55, f, c, s, cd, model_crc({f, c, s, cd}), 8'hAA};
        for (int b = 0; b < 7; b++) begin
            stream[b*10] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                stream[b*10+1+i] = exp_b[b][i];
            end
            stream[b*10+9] = 1'b1;
            dec[b] = 10'h000;
        end
        line_err = 0;
        busy_err = 0;
        done_err = 0;
        done_cnt = 0;

        check_output("ready_before_accept", ready_s, 1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        if (!hold) begin
            ack_valid = 1'b0;
        end
        check_output("busy_after_accept", busy_s, 1);
        check_output("ready_after_accept", ready_s, 0);
        check_output("line_high_accept_cycle", txd_s, 1);

        last_k = (reset_k > 0) ? (reset_k - 1) : (70 * d);
        for (int k = 1; k <= last_k; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            j  = k - 1;
            jb = j / d;
            if (txd_s !== stream[jb]) line_err++;
            if (busy_s !== (k < 70 * d)) busy_err++;
            if (done_s === 1'b1) done_cnt++;
            if (done_s !== (k == 70 * d)) done_err++;
            if ((j % d) == (d / 2)) begin
                dec[jb/10][jb%10] = txd_s;
            end
            if (inject_k > 0 && k == inject_k) begin
                apply_stimulus(f ^ 8'h5A, c ^ 8'h3C, ~s, cd ^ 8'h01);
            end
            if (inject_k > 0 && k == inject_k + 3) begin
                ack_valid = 1'b0;
            end
        end
        check_output("line_per_cycle_errors", line_err, 0);
        check_output("busy_per_cycle_errors", busy_err, 0);
        check_output("done_per_cycle_errors", done_err, 0);

        if (reset_k == 0) begin
            check_output("done_pulse_count", done_cnt, 1);
            check_output("ready_on_done_cycle", ready_s, 1);
            for (int b = 0; b < 7; b++) begin
                check_output($sformatf("start_bit_byte%0d", b), dec[b][0], 0);
                check_output($sformatf("stop_bit_byte%0d", b), dec[b][9], 1);
                check_output($sformatf("data_byte%0d", b), dec[b][8:1], exp_b[b]);
            end
        end else begin
            // Reset in the middle of the frame: it must abort the frame at
            // once and never resume it.
            sys_rst   = 1'b1;
            ack_valid = 1'b0;
            #1;
            check_output("reset_line_high", txd_s, 1);
            check_output("reset_busy_low", busy_s, 0);
            check_output("reset_done_low", done_s, 0);
            repeat (3) @(negedge sys_clk);
            sys_rst = 1'b0;
            check_output("done_count_before_reset", done_cnt, 0);
            check_output("ready_after_reset", ready_s, 1);
            bad = 0;
            for (int k = 0; k < 3 * d; k++) begin
                @(posedge sys_clk);
                @(negedge sys_clk);
                if (txd_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0) bad++;
            end
            check_output("no_resume_after_reset", bad, 0);
        end
    endtask

    initial begin
        logic [7:0] rf, rc, rs, rcd;
        sys_rst   = 1'b1;
        ack_valid = 1'b0;
        ack_func  = 8'h00;
        ack_ch    = 8'h00;
        ack_sta   = 8'h00;
        ack_code  = 8'h00;
        use_def   = 1'b1;

        // Reset values, checked before the first clock edge.
        #2;
        check_output("reset_txd_def", txd_d, 1);
        check_output("reset_busy_def", busy_d, 0);
        check_output("reset_done_def", done_d, 0);
        check_output("reset_ready_def", ready_d, 1);
        check_output("reset_txd_fast", txd_f, 1);
        check_output("reset_busy_fast", busy_f, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        $display("[TB] default-rate frame 02 01 01 00 (bit = %0d cycles)", D_DEF);
        apply_stimulus(8'h02, 8'h01, 8'h01, 8'h00);
        check_frame(8'h02, 8'h01, 8'h01, 8'h00, 1'b0, 0, 0);
        check_idle("idle_after_default_frame", 20);

        use_def = 1'b0;
        @(negedge sys_clk);

        $display("[TB] fast frame 02 01 01 00 and all-zero frame");
        apply_stimulus(8'h02, 8'h01, 8'h01, 8'h00);
        check_frame(8'h02, 8'h01, 8'h01, 8'h00, 1'b0, 0, 0);
        apply_stimulus(8'h00, 8'h00, 8'h00, 8'h00);
        check_frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, 0);

        $display("[TB] request presented mid-frame is ignored");
        apply_stimulus(8'h21, 8'h07, 8'h9C, 8'h01);
        check_frame(8'h21, 8'h07, 8'h9C, 8'h01, 1'b0, 300, 0);
        check_idle("no_frame_after_ignored_request", 4 * D_FAST);

        $display("[TB] ack_valid held high gives two back-to-back frames");
        apply_stimulus(8'h0A, 8'h03, 8'h80, 8'h01);
        check_frame(8'h0A, 8'h03, 8'h80, 8'h01, 1'b1, 0, 0);
        check_frame(8'h0A, 8'h03, 8'h80, 8'h01, 1'b0, 0, 0);
        check_idle("idle_after_back_to_back", 2 * D_FAST);

        $display("[TB] reset during byte 3 data bits, then a clean frame");
        rf = 8'($urandom); rc = 8'($urandom); rs = 8'($urandom); rcd = 8'($urandom_range(0, 1));
        apply_stimulus(rf, rc, rs, rcd);
        check_frame(rf, rc, rs, rcd, 1'b0, 0, 1 + 34 * D_FAST + 2);
        apply_stimulus(8'hC3, 8'h5E, 8'h01, 8'h01);
        check_frame(8'hC3, 8'h5E, 8'h01, 8'h01, 1'b0, 0, 0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 4; n++) begin
            rf  = 8'($urandom);
            rc  = 8'($urandom);
            rs  = 8'($urandom);
            rcd = 8'($urandom);
            apply_stimulus(rf, rc, rs, rcd);
            check_frame(rf, rc, rs, rcd, 1'b0, 0, 0);
            check_idle("idle_between_random", 2 + n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
